// File: rtl/path_pqueue_if.sv
// Push/pop handshake bundle for the Path priority queue.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface path_pqueue_if;
  logic        push_valid_i;
  logic [64:0] push_data_i;
  logic        push_ready_o;
  logic        pop_ready_i;
  logic        pop_valid_o;
  logic [64:0] pop_data_o;

  modport master (
    output push_valid_i, push_data_i, pop_ready_i,
    input  push_ready_o, pop_valid_o, pop_data_o
  );

  modport slave (
    input  push_valid_i, push_data_i, pop_ready_i,
    output push_ready_o, pop_valid_o, pop_data_o
  );
endinterface

// File: rtl/path_pqueue.sv
// Sorted-register priority queue of 65-bit Path records; the minimum (g+h, then g) sits in slot 0.
// Record layout: [64:33] payload, [32:17] g, [16:1] h, [0] tag.
module path_pqueue #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          system1000,
  input  logic          system1000_rstn,
  input  logic          clear_i,
  path_pqueue_if.slave  q,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [1:0]    CMP_LT  = 2'd0;
  localparam logic [1:0]    CMP_EQ  = 2'd1;
  localparam logic [1:0]    CMP_GT  = 2'd2;

  logic [64:0]   e_q   [DEPTH];
  logic [64:0]   e_d   [DEPTH];
  logic [64:0]   base  [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] base_cnt;
  logic [CW-1:0] pos;
  logic          push_fire;
  logic          pop_fire;

  // Three-way compare on (key, g); key wraps at 16 bits.
  function automatic logic [1:0] path_cmp(input logic [64:0] a, input logic [64:0] b);
    logic [15:0] ka;
    logic [15:0] kb;
    ka = a[32:17] + a[16:1];
    kb = b[32:17] + b[16:1];
    if (ka < kb)                  return CMP_LT;
    else if (ka > kb)             return CMP_GT;
    else if (a[32:17] < b[32:17]) return CMP_LT;
    else if (a[32:17] > b[32:17]) return CMP_GT;
    else                          return CMP_EQ;
  endfunction

  assign q.push_ready_o = (count_q != DEPTH_C);
  assign q.pop_valid_o  = (count_q != '0);
  assign q.pop_data_o   = e_q[0];
  assign count_o        = count_q;

  assign push_fire = q.push_valid_i & q.push_ready_o;
  assign pop_fire  = q.pop_ready_i & q.pop_valid_o;

  // A pop first shifts the array down; the push then inserts into what remains.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      base[s] = e_q[s];
      if (pop_fire) begin
        base[s] = (s == DEPTH - 1) ? '0 : e_q[(s + 1) % DEPTH];
      end
    end
    base_cnt = pop_fire ? count_q - 1'b1 : count_q;
  end

  // Entries that compare LT or EQ stay ahead of the newcomer, so ties leave in arrival order.
  always_comb begin
    pos = '0;
    for (int s = 0; s < DEPTH; s++) begin
      if ((CW'(s) < base_cnt) && (path_cmp(base[s], q.push_data_i) != CMP_GT)) begin
        pos = pos + 1'b1;
      end
    end
  end

  always_comb begin
    e_d     = base;
    count_d = base_cnt;
    if (push_fire) begin
      for (int s = 0; s < DEPTH; s++) begin
        if (CW'(s) == pos) begin
          e_d[s] = q.push_data_i;
        end else if (CW'(s) > pos) begin
          e_d[s] = base[(s + DEPTH - 1) % DEPTH];
        end
      end
      count_d = base_cnt + 1'b1;
    end
    if (clear_i) begin
      e_d     = e_q;
      count_d = '0;
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      count_q <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        e_q[s] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int s = 0; s < DEPTH; s++) begin
        e_q[s] <= e_d[s];
      end
    end
  end

endmodule

// File: tb/tb_path_pqueue.sv
// Directed and random bench for path_pqueue with a sorted expected-queue scoreboard.
module tb_path_pqueue;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          system1000      = 1'b0;
  logic          system1000_rstn = 1'b0;
  logic          clear_i         = 1'b0;
  logic [CW-1:0] count_o;

  path_pqueue_if pq ();

  path_pqueue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .clear_i         (clear_i),
    .q               (pq.slave),
    .count_o         (count_o)
  );

  always #5 system1000 = ~system1000;

  logic [64:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [64:0] rec(input logic [15:0] g, input logic [15:0] h,
                                      input logic [31:0] pay, input logic tag);
    return {pay, g, h, tag};
  endfunction

  function automatic logic [15:0] key_of(input logic [64:0] r);
    logic [15:0] k;
    k = r[32:17] + r[16:1];
    return k;
  endfunction

  // Ordering value: key in the upper half, g as tie-break in the lower half.
  function automatic logic [31:0] order_of(input logic [64:0] r);
    return {key_of(r), r[32:17]};
  endfunction

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_push(input logic [64:0] d);
    int i;
    i = 0;
    while (i < exp_q.size() && order_of(exp_q[i]) <= order_of(d)) i++;
    exp_q.insert(i, d);
  endtask

  task automatic check_state();
    chk("count", 65'(count_o), 65'(exp_q.size()));
    chk("pop_valid", 65'(pq.pop_valid_o), 65'(exp_q.size() != 0));
    chk("push_ready", 65'(pq.push_ready_o), 65'(exp_q.size() != DEPTH));
    if (exp_q.size() != 0) chk("head", pq.pop_data_o, exp_q[0]);
  endtask

  task automatic cycle(input logic pv, input logic [64:0] d, input logic pr, input logic clr);
    logic        pf;
    logic        popf;
    logic [64:0] exp_pop;
    @(negedge system1000);
    pq.push_valid_i = pv;
    pq.push_data_i  = d;
    pq.pop_ready_i  = pr;
    clear_i         = clr;
    #1;
    check_state();
    pf   = pv && (exp_q.size() != DEPTH);
    popf = pr && (exp_q.size() != 0);
    if (clr) begin
      exp_q.delete();
    end else begin
      if (popf) begin
        exp_pop = exp_q.pop_front();
        chk("pop_data", pq.pop_data_o, exp_pop);
      end
      if (pf) model_push(d);
    end
    @(posedge system1000);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  logic [64:0] ra, rb, rc, r5;
  int full_keys[8] = '{30, 80, 10, 50, 20, 70, 40, 60};

  initial begin
    pq.push_valid_i = 1'b0;
    pq.push_data_i  = '0;
    pq.pop_ready_i  = 1'b0;

    // Reset state
    #12;
    chk("rst_count", 65'(count_o), 65'd0);
    chk("rst_pop_valid", 65'(pq.pop_valid_o), 65'd0);
    chk("rst_push_ready", 65'(pq.push_ready_o), 65'd1);
    chk("rst_pop_data", pq.pop_data_o, 65'd0);
    @(negedge system1000);
    system1000_rstn = 1'b1;

    // Basic ordering: keys 7, 2, 5 come out as 2, 5, 7
    cycle(1'b1, rec(3, 4, 32'h11, 1'b0), 1'b0, 1'b0);
    cycle(1'b1, rec(1, 1, 32'h22, 1'b1), 1'b0, 1'b0);
    cycle(1'b1, rec(5, 0, 32'h33, 1'b0), 1'b0, 1'b0);
    chk("basic_count", 65'(count_o), 65'd3);
    chk("basic_key0", 65'(key_of(pq.pop_data_o)), 65'd2);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("basic_key1", 65'(key_of(pq.pop_data_o)), 65'd5);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("basic_key2", 65'(key_of(pq.pop_data_o)), 65'd7);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("basic_empty", 65'(pq.pop_valid_o), 65'd0);

    // Tie-break on g, then FIFO among equals
    ra = rec(4, 2, 32'hAAAA, 1'b0);
    rb = rec(2, 4, 32'hBBBB, 1'b1);
    rc = rec(4, 2, 32'hCCCC, 1'b1);
    cycle(1'b1, ra, 1'b0, 1'b0);
    cycle(1'b1, rb, 1'b0, 1'b0);
    cycle(1'b1, rc, 1'b0, 1'b0);
    chk("tie_first_B", pq.pop_data_o, rb);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("tie_second_A", pq.pop_data_o, ra);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("tie_third_C", pq.pop_data_o, rc);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Key wrap-around: 0xFFFF+2 -> 0x0001 beats 0x0005
    ra = rec(16'hFFFF, 16'h0002, 32'h1, 1'b0);
    rb = rec(16'h0001, 16'h0004, 32'h2, 1'b0);
    cycle(1'b1, ra, 1'b0, 1'b0);
    cycle(1'b1, rb, 1'b0, 1'b0);
    chk("wrap_head", pq.pop_data_o, ra);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("wrap_next", pq.pop_data_o, rb);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Fill to DEPTH, then push+pop while full, then push a new minimum with pop
    foreach (full_keys[i])
      cycle(1'b1, rec(16'(full_keys[i]), 16'd0, 32'($urandom_range(0, 65535)), 1'b0), 1'b0, 1'b0);
    chk("full_count", 65'(count_o), 65'd8);
    chk("full_ready", 65'(pq.push_ready_o), 65'd0);
    cycle(1'b1, rec(90, 0, 32'h90, 1'b0), 1'b1, 1'b0);
    chk("full_pop_count", 65'(count_o), 65'd7);
    r5 = rec(5, 0, 32'h55, 1'b1);
    cycle(1'b1, r5, 1'b1, 1'b0);
    chk("simul_head", pq.pop_data_o, r5);
    chk("simul_count", 65'(count_o), 65'd7);

    // Random traffic with small g/h to force ties
    for (int n = 0; n < 80; n++) begin
      cycle(1'($urandom_range(0, 1)),
            rec(16'($urandom_range(0, 6)), 16'($urandom_range(0, 6)), $urandom, 1'($urandom_range(0, 1))),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 29) == 0));
    end
    for (int n = 0; n < DEPTH + 1; n++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", 65'(count_o), 65'd0);

    // Clear wins over a simultaneous push
    for (int n = 0; n < 4; n++) cycle(1'b1, rec(16'(n + 1), 16'd1, 32'(n), 1'b0), 1'b0, 1'b0);
    chk("pre_clear_count", 65'(count_o), 65'd4);
    cycle(1'b1, rec(0, 0, 32'hDEAD, 1'b0), 1'b0, 1'b1);
    chk("clear_count", 65'(count_o), 65'd0);
    chk("clear_ready", 65'(pq.push_ready_o), 65'd1);
    chk("clear_valid", 65'(pq.pop_valid_o), 65'd0);
    idle();

    // Asynchronous reset between clock edges
    cycle(1'b1, rec(9, 9, 32'h99, 1'b0), 1'b0, 1'b0);
    cycle(1'b1, rec(8, 8, 32'h88, 1'b0), 1'b0, 1'b0);
    @(negedge system1000);
    pq.push_valid_i = 1'b0;
    #2;
    system1000_rstn = 1'b0;
    #1;
    chk("arst_count", 65'(count_o), 65'd0);
    chk("arst_valid", 65'(pq.pop_valid_o), 65'd0);
    chk("arst_ready", 65'(pq.push_ready_o), 65'd1);
    chk("arst_data", pq.pop_data_o, 65'd0);
    exp_q.delete();
    @(negedge system1000);
    system1000_rstn = 1'b1;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
